mem_arbiter: RTL

- Two-requester arbiter that shares the single data-memory port between issue lane A (older instruction of the bundle) and lane B (younger).
- Fixed program-order priority: A wins over B. One registered request stage toward memory. Up to MAX_OUT in-order outstanding transactions.
- A tag FIFO records the owner of each transaction so every in-order memory response is routed back to the lane that issued it.
- Sits between the two lanes' load/store logic and the memory block.

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-memory port between issue lane A (older) and
// lane B (younger). A has fixed priority over B, so program order is kept.
// A single registered request stage drives memory. Up to MAX_OUT in-order
// transactions may be outstanding. A tag FIFO records the lane that owns each
// transaction, so every in-order response returns to the lane that issued it.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_x_req_valid/o_x_req_ready, i_x_addr/wdata/we/wstrb   lane x request (x=a,b)
//   o_x_res_valid, o_x_res_rdata                           lane x response (1-cycle pulse)
//   o_mem_req_valid/i_mem_req_ready, o_mem_addr/wdata/we/wstrb  memory request
//   i_mem_res_valid, i_mem_res_rdata                       in-order memory response
//   o_err                      sticky: a response arrived with nothing outstanding
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_a_req_valid,
    output logic                  o_a_req_ready,
    input  logic [ADDR_W-1:0]     i_a_addr,
    input  logic [DATA_W-1:0]     i_a_wdata,
    input  logic                  i_a_we,
    input  logic [DATA_W/8-1:0]   i_a_wstrb,
    input  logic                  i_b_req_valid,
    output logic                  o_b_req_ready,
    input  logic [ADDR_W-1:0]     i_b_addr,
    input  logic [DATA_W-1:0]     i_b_wdata,
    input  logic                  i_b_we,
    input  logic [DATA_W/8-1:0]   i_b_wstrb,
    output logic                  o_a_res_valid,
    output logic [DATA_W-1:0]     o_a_res_rdata,
    output logic                  o_b_res_valid,
    output logic [DATA_W-1:0]     o_b_res_rdata,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic                  o_mem_we,
    output logic [DATA_W/8-1:0]   o_mem_wstrb,
    input  logic                  i_mem_res_valid,
    input  logic [DATA_W-1:0]     i_mem_res_rdata,
    output logic                  o_err
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(MAX_OUT);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [MAX_OUT-1:0] tag_q, tag_d;         // 0 = lane A, 1 = lane B
    logic               req_vld_q, req_vld_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;
    logic               a_res_vld_q, a_res_vld_d, b_res_vld_q, b_res_vld_d;
    logic [DATA_W-1:0]  a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic               err_q, err_d;

    logic can_accept, a_xfer, b_xfer, push, pop, pop_id;

    always_comb begin
        // Readies are gated by reset so every output reads 0 while i_rst is high.
        // No same-cycle bypass: a full count blocks even if a response pops now.
        can_accept    = !i_rst && (count_q < MAX_CNT) && (!req_vld_q || i_mem_req_ready);
        o_a_req_ready = can_accept;
        o_b_req_ready = can_accept && !i_a_req_valid;
        a_xfer        = i_a_req_valid && o_a_req_ready;
        b_xfer        = i_b_req_valid && o_b_req_ready;
        push          = a_xfer || b_xfer;
        // The outstanding count equals FIFO occupancy, so count==0 means empty.
        pop           = i_mem_res_valid && (count_q != '0);
        pop_id        = tag_q[rptr_q];

        req_vld_d = req_vld_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        wstrb_d   = wstrb_q;
        if (a_xfer) begin
            req_vld_d = 1'b1;
            addr_d    = i_a_addr;
            wdata_d   = i_a_wdata;
            we_d      = i_a_we;
            wstrb_d   = i_a_wstrb;
        end else if (b_xfer) begin
            req_vld_d = 1'b1;
            addr_d    = i_b_addr;
            wdata_d   = i_b_wdata;
            we_d      = i_b_we;
            wstrb_d   = i_b_wstrb;
        end else if (req_vld_q && i_mem_req_ready) begin
            req_vld_d = 1'b0;
        end

        // Pointers wrap naturally because MAX_OUT is a power of two.
        tag_d  = tag_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            tag_d[wptr_q] = b_xfer;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) rptr_d = rptr_q + 1'b1;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        a_res_vld_d = pop && !pop_id;
        b_res_vld_d = pop && pop_id;
        a_rdata_d   = a_res_vld_d ? i_mem_res_rdata : a_rdata_q;
        b_rdata_d   = b_res_vld_d ? i_mem_res_rdata : b_rdata_q;

        err_d = err_q || (i_mem_res_valid && (count_q == '0));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            tag_q       <= '0;
            req_vld_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            wstrb_q     <= '0;
            a_res_vld_q <= 1'b0;
            b_res_vld_q <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            tag_q       <= tag_d;
            req_vld_q   <= req_vld_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
            a_res_vld_q <= a_res_vld_d;
            b_res_vld_q <= b_res_vld_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            err_q       <= err_d;
        end
    end

    assign o_mem_req_valid = req_vld_q;
    assign o_mem_addr      = addr_q;
    assign o_mem_wdata     = wdata_q;
    assign o_mem_we        = we_q;
    assign o_mem_wstrb     = wstrb_q;
    assign o_a_res_valid   = a_res_vld_q;
    assign o_a_res_rdata   = a_rdata_q;
    assign o_b_res_valid   = b_res_vld_q;
    assign o_b_res_rdata   = b_rdata_q;
    assign o_err           = err_q;
endmodule
